perf_cnt_bank: RTL and testbench

- Parametrised bank of event counters with an AXI4-Lite slave port; generalises the fixed 16-output perf-counter wiring of the CPU test top.
- The CPU core drives one increment strobe per channel. Host or CPU software reads, presets, clears and snapshots the counters over the cpu_perf_cnt AXI-Lite interface.
- Sits beside cpu_wrapper in the test top, on the same clock domain.

---
 rtl/perf_cnt_bank.sv | 224 ++++++++++++++++++++++
 tb/tb_perf_cnt_bank.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_cnt_bank.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// perf_cnt_bank
//   Bank of NUM_CNT event counters (CNT_W bits each) with an AXI4-Lite slave
//   port. Each channel counts its evt_inc strobe while CTRL.EN is set.
//   Software can preset counters (byte-strobed writes), clear all counters,
//   snapshot all counters into shadow registers and choose whether counter
//   reads return live or shadow values.
//
//   Register map (byte offsets, decoded on addr[ADDR_W-1:2]):
//     0x000 + 4*i  counter i (i < NUM_CNT), zero-extended to 32 bits
//     0x100        CTRL: bit0 EN (R/W), bit1 SNAP (W1 pulse), bit2 CLR (W1
//                  pulse), bit3 USE_SNAP (R/W)
//     0x104        ID (read-only): {ID_TAG, CNT_W[7:0], NUM_CNT[7:0]}
//     other        unmapped: SLVERR, reads return 0
//
// Ports:
//   cpu_clk, cpu_reset     clock, synchronous active-high reset
//   evt_inc[NUM_CNT]       per-channel increment strobes
//   s_aw*/s_w*/s_b*        AXI-Lite write channels (AW and W accepted together)
//   s_ar*/s_r*             AXI-Lite read channels
// ---------------------------------------------------------------------------
module perf_cnt_bank #(
  parameter int          NUM_CNT = 16,
  parameter int          CNT_W   = 32,
  parameter int          ADDR_W  = 12,
  // 'PC01' tag: 'P' is not a hex digit, so it is carried as 0xF.
  parameter logic [15:0] ID_TAG  = 16'hFC01
) (
  input  logic               cpu_clk,
  input  logic               cpu_reset,
  input  logic [NUM_CNT-1:0] evt_inc,
  input  logic [ADDR_W-1:0]  s_awaddr,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [31:0]        s_wdata,
  input  logic [3:0]         s_wstrb,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready,
  input  logic [ADDR_W-1:0]  s_araddr,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [31:0]        s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rvalid,
  input  logic               s_rready
);

  localparam int               IDX_W       = ADDR_W - 2;
  localparam logic [IDX_W-1:0] CTRL_IDX    = IDX_W'(64);  // 0x100
  localparam logic [IDX_W-1:0] ID_IDX      = IDX_W'(65);  // 0x104
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  // Control / response state
  logic        r_en;
  logic        r_use_snap;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  // Per-channel values gathered from the generate blocks
  logic [CNT_W-1:0] w_cnt [NUM_CNT];
  logic [CNT_W-1:0] w_shd [NUM_CNT];

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [IDX_W-1:0] w_aw_idx;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_aw_is_cnt;
  logic             w_ar_is_cnt;
  logic             w_ctrl_wr;
  logic             w_snap;
  logic             w_clr;
  logic [31:0]      w_wmask;
  logic [31:0]      w_cnt_rd;
  logic [31:0]      w_rd_data;
  logic [1:0]       w_rd_resp;
  logic             w_addr_lsb_unused;

  // Byte offsets are word aligned; the two low address bits carry no meaning.
  assign w_addr_lsb_unused = ^{s_awaddr[1:0], s_araddr[1:0]};

  // Both write channels are taken in a single cycle and only when no write
  // response is still pending. Readies are forced low during reset.
  assign w_wr_acc  = !cpu_reset && s_awvalid && s_wvalid && !r_bvalid;
  assign w_rd_acc  = !cpu_reset && s_arvalid && !r_rvalid;
  assign s_awready = w_wr_acc;
  assign s_wready  = w_wr_acc;
  assign s_arready = w_rd_acc;

  assign w_aw_idx    = s_awaddr[ADDR_W-1:2];
  assign w_ar_idx    = s_araddr[ADDR_W-1:2];
  assign w_aw_is_cnt = (32'(w_aw_idx) < 32'(NUM_CNT));
  assign w_ar_is_cnt = (32'(w_ar_idx) < 32'(NUM_CNT));

  // All CTRL bits live in byte lane 0, so lane 0 gates every CTRL effect.
  assign w_ctrl_wr = w_wr_acc && (w_aw_idx == CTRL_IDX) && s_wstrb[0];
  assign w_snap    = w_ctrl_wr && s_wdata[1];
  assign w_clr     = w_ctrl_wr && s_wdata[2];

  assign w_wmask = {{8{s_wstrb[3]}}, {8{s_wstrb[2]}}, {8{s_wstrb[1]}}, {8{s_wstrb[0]}}};

  // -------------------------------------------------------------------------
  // Counter channels
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_shd;
      logic             w_hit;
      logic [CNT_W-1:0] w_wr_val;

      assign w_hit = w_wr_acc && (w_aw_idx == IDX_W'(gi));
      // Unstrobed lanes keep the current value; bits above CNT_W are dropped.
      assign w_wr_val = CNT_W'((s_wdata & w_wmask) | (32'(r_cnt) & ~w_wmask));

      always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
          r_cnt <= '0;
          r_shd <= '0;
        end else begin
          // Snapshot takes the value before this cycle's clear/write/increment.
          if (w_snap) begin
            r_shd <= r_cnt;
          end
          // Priority: clear, then software write, then event increment.
          if (w_clr) begin
            r_cnt <= '0;
          end else if (w_hit) begin
            r_cnt <= w_wr_val;
          end else if (r_en && evt_inc[gi]) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_cnt[gi] = r_cnt;
      assign w_shd[gi] = r_shd;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // CTRL register
  // -------------------------------------------------------------------------
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      r_en       <= 1'b1;
      r_use_snap <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en       <= s_wdata[0];
      r_use_snap <= s_wdata[3];
    end
  end

  // -------------------------------------------------------------------------
  // Write response
  // -------------------------------------------------------------------------
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_acc) begin
      r_bvalid <= 1'b1;
      r_bresp  <= (w_aw_is_cnt || (w_aw_idx == CTRL_IDX)) ? RESP_OKAY : RESP_SLVERR;
    end else if (s_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  assign s_bvalid = r_bvalid;
  assign s_bresp  = r_bresp;

  // -------------------------------------------------------------------------
  // Read path: data is taken from register state before this cycle's update,
  // so a same-cycle write to the same register is not visible yet.
  // -------------------------------------------------------------------------
  always_comb begin
    w_cnt_rd = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (w_ar_idx == IDX_W'(k)) begin
        w_cnt_rd = 32'(r_use_snap ? w_shd[k] : w_cnt[k]);
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    if (w_ar_is_cnt) begin
      w_rd_data = w_cnt_rd;
    end else if (w_ar_idx == CTRL_IDX) begin
      w_rd_data = {28'd0, r_use_snap, 2'b00, r_en};
    end else if (w_ar_idx == ID_IDX) begin
      w_rd_data = {ID_TAG, 8'(CNT_W), 8'(NUM_CNT)};
    end else begin
      w_rd_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_rd_acc) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (s_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_rvalid = r_rvalid;
  assign s_rdata  = r_rdata;
  assign s_rresp  = r_rresp;

endmodule

// File: tb/tb_perf_cnt_bank.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_perf_cnt_bank
//   Two instances share one AXI-Lite driver: dut_a (16 x 32-bit, modelled)
//   and dut_b (4 x 8-bit, checked against constants). 'sel' picks which one
//   sees valid strobes and events. dut_a is checked against a register-level
//   model updated once per clock from the bus and event activity.
// ---------------------------------------------------------------------------
module tb_perf_cnt_bank;

  logic cpu_clk = 1'b0;
  logic cpu_reset;
  always #5 cpu_clk = ~cpu_clk;

  logic        sel;
  logic [15:0] evt;
  logic        evt_rand;
  logic [11:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic [1:0]  a_bresp, a_rresp;
  logic [31:0] a_rdata;
  logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0]  b_bresp, b_rresp;
  logic [31:0] b_rdata;

  logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata;

  perf_cnt_bank #(.NUM_CNT(16), .CNT_W(32), .ADDR_W(12)) dut_a (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .evt_inc(sel ? 16'h0 : evt),
    .s_awaddr(awaddr), .s_awvalid(awvalid & ~sel), .s_awready(a_awready),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid & ~sel), .s_wready(a_wready),
    .s_bresp(a_bresp), .s_bvalid(a_bvalid), .s_bready(bready),
    .s_araddr(araddr), .s_arvalid(arvalid & ~sel), .s_arready(a_arready),
    .s_rdata(a_rdata), .s_rresp(a_rresp), .s_rvalid(a_rvalid), .s_rready(rready));

  perf_cnt_bank #(.NUM_CNT(4), .CNT_W(8), .ADDR_W(12)) dut_b (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .evt_inc(sel ? evt[3:0] : 4'h0),
    .s_awaddr(awaddr), .s_awvalid(awvalid & sel), .s_awready(b_awready),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid & sel), .s_wready(b_wready),
    .s_bresp(b_bresp), .s_bvalid(b_bvalid), .s_bready(bready),
    .s_araddr(araddr), .s_arvalid(arvalid & sel), .s_arready(b_arready),
    .s_rdata(b_rdata), .s_rresp(b_rresp), .s_rvalid(b_rvalid), .s_rready(rready));

  assign o_awready = sel ? b_awready : a_awready;
  assign o_wready  = sel ? b_wready  : a_wready;
  assign o_bvalid  = sel ? b_bvalid  : a_bvalid;
  assign o_bresp   = sel ? b_bresp   : a_bresp;
  assign o_arready = sel ? b_arready : a_arready;
  assign o_rvalid  = sel ? b_rvalid  : a_rvalid;
  assign o_rresp   = sel ? b_rresp   : a_rresp;
  assign o_rdata   = sel ? b_rdata   : a_rdata;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (dut_a) ----------------
  logic [31:0] m_cnt [16];
  logic [31:0] m_shd [16];
  logic        m_en, m_usnap;
  logic [31:0] x_rdata;
  logic [1:0]  x_rresp, x_bresp;
  logic        last_wacc, last_racc;

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 0;
      m_shd[i] = 0;
    end
    m_en = 1'b1;
    m_usnap = 1'b0;
  endtask

  function automatic logic [33:0] m_read(input logic [11:0] a);
    int idx;
    idx = int'(a) / 4;
    if (idx < 16)       return {2'b00, (m_usnap ? m_shd[idx] : m_cnt[idx])};
    else if (idx == 64) return {2'b00, 28'd0, m_usnap, 2'b00, m_en};
    else if (idx == 65) return {2'b00, 32'hFC01_2010};
    else                return {2'b10, 32'd0};
  endfunction

  // One clock cycle with the currently driven inputs; updates the model.
  task automatic step();
    logic wacc, racc, snap, clr, n_en, n_us;
    int   idx, nc;
    logic [31:0] v;
    if (evt_rand) evt = 16'($urandom);
    #1;
    wacc = o_awready;
    racc = o_arready;
    if (awvalid || wvalid) begin
      chk("awready", {31'd0, o_awready}, {31'd0, awvalid && wvalid && !o_bvalid && !cpu_reset});
      chk("wready_pair", {31'd0, o_wready}, {31'd0, o_awready});
    end
    if (arvalid)
      chk("arready", {31'd0, o_arready}, {31'd0, !o_rvalid && !cpu_reset});
    @(posedge cpu_clk);
    last_wacc = wacc;
    last_racc = racc;
    nc  = sel ? 4 : 16;
    idx = int'(awaddr) / 4;
    if (wacc) x_bresp = (idx < nc || idx == 64) ? 2'b00 : 2'b10;
    if (cpu_reset) begin
      if (!sel) m_reset();
    end else if (!sel) begin
      if (racc) {x_rresp, x_rdata} = m_read(araddr);
      snap = 0; clr = 0; n_en = m_en; n_us = m_usnap;
      if (wacc && idx == 64 && wstrb[0]) begin
        n_en = wdata[0]; snap = wdata[1]; clr = wdata[2]; n_us = wdata[3];
      end
      for (int i = 0; i < 16; i++) begin
        if (snap) m_shd[i] = m_cnt[i];
        if (clr) m_cnt[i] = 0;
        else if (wacc && idx == i) begin
          v = m_cnt[i];
          for (int b = 0; b < 4; b++) if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
          m_cnt[i] = v;
        end else if (m_en && evt[i]) m_cnt[i] = m_cnt[i] + 1;
      end
      m_en = n_en;
      m_usnap = n_us;
    end
    @(negedge cpu_clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 0;
    do begin step(); n++; end while (!last_wacc && n < 8);
    if (!last_wacc) chk("aw_timeout", 0, 1);
    awvalid = 0; wvalid = 0;
    chk("bvalid", {31'd0, o_bvalid}, 1);
    chk("bresp", {30'd0, o_bresp}, {30'd0, x_bresp});
    bready = 1; step(); bready = 0;
    chk("bvalid_clr", {31'd0, o_bvalid}, 0);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    araddr = a; arvalid = 1; rready = 0;
    do begin step(); n++; end while (!last_racc && n < 8);
    if (!last_racc) chk("ar_timeout", 0, 1);
    arvalid = 0;
    chk("rvalid", {31'd0, o_rvalid}, 1);
    d = o_rdata; r = o_rresp;
    rready = 1; step(); rready = 0;
    chk("rvalid_clr", {31'd0, o_rvalid}, 0);
  endtask

  task automatic rd_model(input string tag, input logic [11:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    rd(a, d, r);
    chk(tag, d, x_rdata);
    chk({tag, "_resp"}, {30'd0, r}, {30'd0, x_rresp});
  endtask

  task automatic rd_const(input string tag, input logic [11:0] a,
                          input logic [31:0] ed, input logic [1:0] er);
    logic [31:0] d;
    logic [1:0]  r;
    rd(a, d, r);
    chk(tag, d, ed);
    chk({tag, "_resp"}, {30'd0, r}, {30'd0, er});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    sel = 0; evt = 0; evt_rand = 0; cpu_reset = 1;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
    x_bresp = 0; x_rresp = 0; x_rdata = 0; last_wacc = 0; last_racc = 0;
    m_reset();
    @(negedge cpu_clk);
    repeat (3) step();
    #1;
    chk("rst_awready", {31'd0, o_awready}, 0);
    chk("rst_arready", {31'd0, o_arready}, 0);
    chk("rst_bvalid", {31'd0, o_bvalid}, 0);
    chk("rst_rvalid", {31'd0, o_rvalid}, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_resp", {28'd0, o_bresp, o_rresp}, 0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    step();
    cpu_reset = 0;
    step();

    rd_const("ctrl_rst", 12'h100, 32'h1, 2'b00);
    rd_const("id", 12'h104, 32'hFC01_2010, 2'b00);

    // Counting with EN=1, then hold with EN=0
    evt = 16'h0008; repeat (10) step(); evt = 0;
    rd_const("cnt3_10", 12'h00C, 32'd10, 2'b00);
    wr(12'h100, 32'h0, 4'hF);
    evt = 16'h0008; repeat (5) step(); evt = 0;
    rd_const("cnt3_hold", 12'h00C, 32'd10, 2'b00);
    wr(12'h100, 32'h1, 4'hF);

    // Write beats same-cycle increment, next increment wraps
    evt = 16'h0004;
    wr(12'h008, 32'hFFFF_FFFF, 4'hF);
    evt = 0;
    rd_const("cnt2_wrap", 12'h008, 32'h0, 2'b00);

    // SNAP + CLR + USE_SNAP
    wr(12'h000, 32'd7, 4'hF);
    wr(12'h100, 32'hF, 4'hF);
    rd_const("snap_read", 12'h000, 32'd7, 2'b00);
    evt = 16'h0001; repeat (3) step(); evt = 0;
    wr(12'h100, 32'h1, 4'hF);
    rd_const("live_after_clr", 12'h000, 32'd3, 2'b00);
    rd_const("cnt3_cleared", 12'h00C, 32'd0, 2'b00);

    // Unmapped / read-only
    rd_const("unmapped", 12'h200, 32'h0, 2'b10);
    wr(12'h104, 32'h0, 4'hF);
    chk("id_wr_bresp", {30'd0, o_bresp}, 32'h2);
    rd_const("id_kept", 12'h104, 32'hFC01_2010, 2'b00);

    // Hold rready low: response stable, no second accept
    araddr = 12'h104; arvalid = 1; rready = 0;
    step();
    chk("hold_acc", {31'd0, last_racc}, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_rvalid", {31'd0, o_rvalid}, 1);
      chk("hold_rdata", o_rdata, 32'hFC01_2010);
      chk("hold_no_acc", {31'd0, last_racc}, 0);
    end
    arvalid = 0; rready = 1; step(); rready = 0;

    // Same-cycle read and write of one register; byte strobes
    wr(12'h014, 32'h55, 4'hF);
    araddr = 12'h014; arvalid = 1; awaddr = 12'h014; wdata = 32'hAA; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0; rready = 0;
    step();
    arvalid = 0; awvalid = 0; wvalid = 0;
    chk("rw_same_rdata", o_rdata, 32'h55);
    chk("rw_same_model", o_rdata, x_rdata);
    chk("rw_same_bvalid", {31'd0, o_bvalid}, 1);
    bready = 1; rready = 1; step(); bready = 0; rready = 0;
    wr(12'h014, 32'h1234_5678, 4'b0101);
    rd_const("strobe", 12'h014, 32'h0034_0078, 2'b00);

    // Randomized traffic against the model
    evt_rand = 1;
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2)
        wr(12'($urandom_range(0, 15) * 4), $urandom, 4'($urandom_range(1, 15)));
      else if (op == 3)
        wr(12'h100, 32'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0) ? 4'hF : 4'hE);
      else if (op == 4)
        wr(12'($urandom_range(0, 4095)), $urandom, 4'hF);
      else if (op <= 7) begin
        int s;
        s = $urandom_range(0, 5);
        if (s <= 3)      rd_model("rnd_cnt", 12'($urandom_range(0, 15) * 4));
        else if (s == 4) rd_model("rnd_ctrl", 12'h100);
        else             rd_model("rnd_any", 12'($urandom_range(0, 4095)));
      end else
        repeat ($urandom_range(1, 4)) step();
    end
    evt_rand = 0; evt = 0;
    wr(12'h100, 32'h1, 4'hF);
    for (int i = 0; i < 16; i++) rd_model("final_cnt", 12'(i * 4));

    // Narrow instance: truncation, 8-bit wrap, smaller map
    sel = 1;
    wr(12'h004, 32'h1FF, 4'hF);
    chk("b_bresp_ok", {30'd0, o_bresp}, 0);
    rd_const("b_trunc", 12'h004, 32'hFF, 2'b00);
    rd_const("b_id", 12'h104, 32'hFC01_0804, 2'b00);
    wr(12'h010, 32'h1, 4'hF);
    chk("b_bresp_unmapped", {30'd0, o_bresp}, 2);
    wr(12'h000, 32'hFE, 4'hF);
    evt = 16'h0001; repeat (2) step(); evt = 0;
    rd_const("b_wrap", 12'h000, 32'h0, 2'b00);
    sel = 0;

    // Reset while a write response is pending
    awaddr = 12'h010; wdata = 32'd5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    step();
    awvalid = 0; wvalid = 0;
    chk("pre_rst_bvalid", {31'd0, o_bvalid}, 1);
    cpu_reset = 1; step(); cpu_reset = 0;
    chk("mid_rst_bvalid", {31'd0, o_bvalid}, 0);
    rd_const("rst_cnt4", 12'h010, 32'h0, 2'b00);
    rd_const("rst_cnt0", 12'h000, 32'h0, 2'b00);
    rd_const("rst_ctrl", 12'h100, 32'h1, 2'b00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
